// File: rtl/disp_rx_pkg.sv
// Shared types and frame-width constants for the serial display receiver.
package disp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } rx_state_e;

  localparam int SEG_FRAME_W = 64;
  localparam int LED_FRAME_W = 16;

endpackage

// File: rtl/serial_disp_rx_sync_edge.sv
// Multi-flop synchroniser for one serial line plus a rising-edge detector
// that compares the synchronised value against a one-cycle-delayed copy.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  // next values of the synchroniser chain and the delayed copy
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], din};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  // synchroniser and delay registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/serial_disp_rx.sv
// Receiver for the 7-segment / LED serial shift chain: oversamples the serial
// lines, rebuilds the shifted word and latches it on the pen strobe.
module serial_disp_rx
  import disp_rx_pkg::*;
#(
  parameter int WIDTH       = SEG_FRAME_W,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_clk,
  input  logic                        s_sout,
  input  logic                        s_pen,
  input  logic                        s_clrn,
  output logic [WIDTH-1:0]            data_out,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic [$clog2(WIDTH+2)-1:0]  bit_cnt,
  output logic                        busy
);

  localparam int            CW       = $clog2(WIDTH+2);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

  logic clk_rise, pen_rise, clrn_sync;
  logic clk_sync_unused, pen_sync_unused, clrn_rise_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .din(s_clk), .sync_o(clk_sync_unused), .rise_o(clk_rise)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pen (
    .clk(clk), .rst(rst), .din(s_pen), .sync_o(pen_sync_unused), .rise_o(pen_rise)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clrn (
    .clk(clk), .rst(rst), .din(s_clrn), .sync_o(clrn_sync), .rise_o(clrn_rise_unused)
  );

  // Data line gets the same depth as s_clk so each bit lines up with its edge.
  logic [SYNC_STAGES-1:0] sout_q, sout_d;
  logic                   sout_sync;

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d, base_cnt;
  logic             valid_q, valid_d, err_q, err_d, busy_q, busy_d;

  assign sout_sync = sout_q[SYNC_STAGES-1];

  // next-state, shift and frame-latch logic
  always_comb begin
    sout_d     = {sout_q[SYNC_STAGES-2:0], s_sout};
    state_d    = state_q;
    sreg_d     = sreg_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    base_cnt   = cnt_q;
    sreg_shift = sreg_q;

    if (MSB_FIRST) begin
      sreg_shift = {sreg_q[WIDTH-2:0], sout_sync};
    end else begin
      sreg_shift = {sout_sync, sreg_q[WIDTH-1:1]};
    end

    if (!clrn_sync) begin
      sreg_d  = {WIDTH{1'b0}};
      data_d  = {WIDTH{1'b0}};
      cnt_d   = CNT_ZERO;
      state_d = IDLE;
    end else begin
      // The pen is judged on the count before any concurrent shift.
      if (pen_rise) begin
        if (state_q == FULL) begin
          data_d  = sreg_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        base_cnt = CNT_ZERO;
      end else begin
        base_cnt = cnt_q;
      end

      if (clk_rise && (base_cnt != CNT_OVER)) begin
        sreg_d = sreg_shift;
        cnt_d  = base_cnt + CNT_ONE;
      end else begin
        cnt_d = base_cnt;
      end

      if (cnt_d == CNT_ZERO) begin
        state_d = IDLE;
      end else if (cnt_d == CNT_FULL) begin
        state_d = FULL;
      end else if (cnt_d == CNT_OVER) begin
        state_d = OVER;
      end else begin
        state_d = SHIFT;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sout_q  <= {SYNC_STAGES{1'b0}};
      sreg_q  <= {WIDTH{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign bit_cnt     = cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_disp_rx.sv
// Bench for serial_disp_rx: a 64-bit MSB-first seg chain and a 16-bit
// LSB-first LED chain, both checked every cycle against a frame-level model.
module tb_serial_disp_rx;
  import disp_rx_pkg::*;

  localparam int LAT  = 3;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] s_clk_v  = 2'b00;
  logic [1:0] s_sout_v = 2'b00;
  logic [1:0] s_pen_v  = 2'b00;
  logic [1:0] s_clrn_v = 2'b11;

  logic [63:0] d0;
  logic [15:0] d1;
  logic [6:0]  c0;
  logic [4:0]  c1;
  logic [1:0]  fv, fe, bz;

  always #5 clk = ~clk;

  serial_disp_rx #(.WIDTH(SEG_FRAME_W), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_seg (
    .clk(clk), .rst(rst), .s_clk(s_clk_v[0]), .s_sout(s_sout_v[0]), .s_pen(s_pen_v[0]),
    .s_clrn(s_clrn_v[0]), .data_out(d0), .frame_valid(fv[0]), .frame_err(fe[0]),
    .bit_cnt(c0), .busy(bz[0])
  );

  serial_disp_rx #(.WIDTH(LED_FRAME_W), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_led (
    .clk(clk), .rst(rst), .s_clk(s_clk_v[1]), .s_sout(s_sout_v[1]), .s_pen(s_pen_v[1]),
    .s_clrn(s_clrn_v[1]), .data_out(d1), .frame_valid(fv[1]), .frame_err(fe[1]),
    .bit_cnt(c1), .busy(bz[1])
  );

  // Frame-level model: bits received so far, count, last latched word.
  int          m_cnt  [2] = '{0, 0};
  logic [63:0] m_bits [2] = '{64'd0, 64'd0};
  logic [63:0] m_data [2] = '{64'd0, 64'd0};
  int          m_vev  [2] = '{0, 0};
  int          m_eev  [2] = '{0, 0};

  int lit_tests = 0, lit_fail = 0, cyc_tests = 0, cyc_fail = 0;
  int vpulses [2] = '{0, 0};
  int epulses [2] = '{0, 0};

  function automatic int wof(bit ch);
    return (ch == 1'b0) ? 64 : 16;
  endfunction

  task automatic model_bit(bit ch, logic b);
    if (m_cnt[ch] == 0) m_bits[ch] = 64'd0;
    if (m_cnt[ch] < wof(ch)) m_bits[ch] = m_bits[ch] | (64'(b) << m_cnt[ch]);
    if (m_cnt[ch] <= wof(ch)) m_cnt[ch] = m_cnt[ch] + 1;
  endtask

  task automatic model_pen(bit ch);
    if (m_cnt[ch] == wof(ch)) begin
      m_data[ch] = 64'd0;
      for (int i = 0; i < wof(ch); i++) begin
        logic b;
        b = ((m_bits[ch] >> i) & 64'd1) != 64'd0;
        if (ch == 1'b0) m_data[ch] = m_data[ch] | (64'(b) << (wof(ch) - 1 - i));
        else            m_data[ch] = m_data[ch] | (64'(b) << i);
      end
      m_vev[ch] = m_vev[ch] + 1;
    end else begin
      m_eev[ch] = m_eev[ch] + 1;
    end
    m_cnt[ch] = 0;
  endtask

  task automatic model_clear(bit ch);
    m_cnt[ch]  = 0;
    m_data[ch] = 64'd0;
  endtask

  // Expected outputs lag the pin activity by the synchroniser latency.
  typedef struct {
    logic [63:0] data;
    int          cnt;
    logic        busy;
    logic        v;
    logic        e;
  } snap_t;

  snap_t h1 [2], h2 [2], h3 [2];
  int    seen_v [2] = '{0, 0};
  int    seen_e [2] = '{0, 0};

  task automatic cmp_ch(bit ch);
    snap_t       cur, exp;
    logic [63:0] gd;
    int          gc;
    logic        gv, ge, gb;
    cur.data = m_data[ch];
    cur.cnt  = m_cnt[ch];
    cur.busy = (m_cnt[ch] != 0);
    cur.v    = (m_vev[ch] != seen_v[ch]);
    cur.e    = (m_eev[ch] != seen_e[ch]);
    seen_v[ch] = m_vev[ch];
    seen_e[ch] = m_eev[ch];
    if (rst) begin
      cur.v = 1'b0;
      cur.e = 1'b0;
      h1[ch] = cur;
      h2[ch] = cur;
      h3[ch] = cur;
    end
    exp = h3[ch];
    h3[ch] = h2[ch];
    h2[ch] = h1[ch];
    h1[ch] = cur;
    if (ch == 1'b0) begin
      gd = d0; gc = int'(c0); gv = fv[0]; ge = fe[0]; gb = bz[0];
    end else begin
      gd = {48'd0, d1}; gc = int'(c1); gv = fv[1]; ge = fe[1]; gb = bz[1];
    end
    if (gv === 1'b1) vpulses[ch] = vpulses[ch] + 1;
    if (ge === 1'b1) epulses[ch] = epulses[ch] + 1;
    cyc_tests = cyc_tests + 1;
    if (gd !== exp.data || gc != exp.cnt || gv !== exp.v || ge !== exp.e || gb !== exp.busy) begin
      cyc_fail = cyc_fail + 1;
      if (cyc_fail <= 20)
        $display("FAIL cycle ch%0d t=%0t: got data=%h cnt=%0d v=%b e=%b busy=%b, want data=%h cnt=%0d v=%b e=%b busy=%b",
                 ch, $time, gd, gc, gv, ge, gb, exp.data, exp.cnt, exp.v, exp.e, exp.busy);
    end
  endtask

  // per-cycle comparison against the delayed model
  always @(negedge clk) begin
    cmp_ch(1'b0);
    cmp_ch(1'b1);
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    lit_tests = lit_tests + 1;
    if (got !== exp) begin
      lit_fail = lit_fail + 1;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic bitsel(bit ch, logic [63:0] v, int i);
    int idx;
    idx = (ch == 1'b0) ? (63 - (i % 64)) : (i % 16);
    return ((v >> idx) & 64'd1) != 64'd0;
  endfunction

  task automatic send_bit(bit ch, logic b);
    s_sout_v[ch] = b;
    tick(HOLD);
    s_clk_v[ch] = 1'b1;
    model_bit(ch, b);
    tick(HOLD);
    s_clk_v[ch] = 1'b0;
  endtask

  task automatic send_frame(bit ch, logic [63:0] v, int n);
    for (int i = 0; i < n; i++) send_bit(ch, bitsel(ch, v, i));
    tick(1);
  endtask

  task automatic pen(bit ch);
    s_pen_v[ch] = 1'b1;
    model_pen(ch);
    tick(HOLD);
    s_pen_v[ch] = 1'b0;
    tick(HOLD);
  endtask

  task automatic pen_and_bit(bit ch, logic b);
    s_sout_v[ch] = b;
    tick(HOLD);
    s_pen_v[ch] = 1'b1;
    s_clk_v[ch] = 1'b1;
    model_pen(ch);
    model_bit(ch, b);
    tick(HOLD);
    s_pen_v[ch] = 1'b0;
    s_clk_v[ch] = 1'b0;
    tick(HOLD);
  endtask

  task automatic clear(bit ch);
    s_clrn_v[ch] = 1'b0;
    model_clear(ch);
    tick(5);
    s_clrn_v[ch] = 1'b1;
    tick(HOLD);
  endtask

  task automatic random_frames(bit ch, int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] v;
      int          kind;
      v    = {$urandom(), $urandom()};
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        send_frame(ch, v, wof(ch) - m_cnt[ch]);
        pen(ch);
      end else if (kind == 6) begin
        send_frame(ch, v, int'($urandom_range(0, 15)));
        pen(ch);
      end else if (kind == 7) begin
        send_frame(ch, v, wof(ch) + int'($urandom_range(1, 4)));
        pen(ch);
      end else if (kind == 8) begin
        send_frame(ch, v, int'($urandom_range(1, 10)));
        clear(ch);
      end else begin
        send_frame(ch, v, wof(ch) - m_cnt[ch]);
        pen_and_bit(ch, v[0]);
      end
    end
  endtask

  int v0, e0;

  initial begin
    tick(4);
    check("reset_data", d0, 64'd0);
    check("reset_cnt", 64'(c0), 64'd0);
    check("reset_busy", 64'(bz[0]), 64'd0);
    rst = 1'b0;
    tick(3);

    v0 = vpulses[0];
    send_frame(1'b0, 64'h0123456789ABCDEF, 64);
    check("good_cnt_full", 64'(c0), 64'd64);
    pen(1'b0);
    check("good_data", d0, 64'h0123456789ABCDEF);
    check("good_one_valid", 64'(vpulses[0] - v0), 64'd1);
    check("good_cnt_zero", 64'(c0), 64'd0);
    check("good_busy", 64'(bz[0]), 64'd0);

    e0 = epulses[0];
    send_frame(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 63);
    pen(1'b0);
    check("under_err", 64'(epulses[0] - e0), 64'd1);
    check("under_data", d0, 64'h0123456789ABCDEF);

    e0 = epulses[0];
    send_frame(1'b0, 64'h5555_AAAA_3333_CCCC, 70);
    check("over_cnt", 64'(c0), 64'd65);
    pen(1'b0);
    check("over_err", 64'(epulses[0] - e0), 64'd1);
    check("over_data", d0, 64'h0123456789ABCDEF);

    v0 = vpulses[0];
    e0 = epulses[0];
    send_frame(1'b0, 64'h1357_9BDF_2468_ACE0, 30);
    clear(1'b0);
    check("clr_data", d0, 64'd0);
    check("clr_cnt", 64'(c0), 64'd0);
    check("clr_no_pulse", 64'((vpulses[0] - v0) + (epulses[0] - e0)), 64'd0);
    send_frame(1'b0, 64'hA5A5A5A5A5A5A5A5, 64);
    pen(1'b0);
    check("clr_then_frame", d0, 64'hA5A5A5A5A5A5A5A5);

    send_frame(1'b0, 64'hFEDCBA9876543210, 64);
    v0 = vpulses[0];
    pen_and_bit(1'b0, 1'b1);
    check("coinc_data", d0, 64'hFEDCBA9876543210);
    check("coinc_valid", 64'(vpulses[0] - v0), 64'd1);
    check("coinc_cnt", 64'(c0), 64'd1);
    check("coinc_busy", 64'(bz[0]), 64'd1);
    for (int i = 1; i < 64; i++) send_bit(1'b0, bitsel(1'b0, 64'h8000_0000_0000_0001, i));
    tick(1);
    pen(1'b0);
    check("coinc_next_frame", d0, 64'h8000_0000_0000_0001);

    send_frame(1'b1, 64'h0000_0000_0000_BEEF, 16);
    pen(1'b1);
    check("led_data", {48'd0, d1}, 64'h0000_0000_0000_BEEF);

    random_frames(1'b0, 8);
    random_frames(1'b1, 12);

    send_frame(1'b1, 64'h0000_0000_0000_1234, 5);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    s_clk_v  = 2'b00;
    s_pen_v  = 2'b00;
    s_sout_v = 2'b00;
    s_clrn_v = 2'b11;
    model_clear(1'b0);
    model_clear(1'b1);
    #1;
    check("rst_led_data", {48'd0, d1}, 64'd0);
    check("rst_led_cnt", 64'(c1), 64'd0);
    check("rst_led_flags", {61'd0, fv[1], fe[1], bz[1]}, 64'd0);
    check("rst_seg_data", d0, 64'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    random_frames(1'b1, 6);
    tick(8);
    $display("[TB] %0d tests run, %0d failed", lit_tests + cyc_tests, lit_fail + cyc_fail);
    $finish;
  end

endmodule
